// File: rtl/axis_packet_source_pkg.sv
// Shared definitions for the AXI-Stream packet source: FSM states and payload layout.
package axis_packet_source_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int unsigned SEQ_LSB   = 0;
    localparam int unsigned FRAME_LSB = 64;
    localparam int unsigned PKT_LSB   = 96;
    localparam int unsigned TAG_LSB   = 112;

    localparam int unsigned SEQ_W   = 64;
    localparam int unsigned FRAME_W = 32;
    localparam int unsigned PKT_W   = 16;
    localparam int unsigned TAG_W   = 16;

    localparam logic [TAG_W-1:0] PAYLOAD_TAG = 16'hC0DE;

endpackage

// File: rtl/axis_packet_source.sv
// AXI-Stream traffic source: emits framed, packetised, self-describing beats under tready
// backpressure, with optional inter-packet gaps and per-run progress counters.
module axis_packet_source
    import axis_packet_source_pkg::*;
#(
    parameter int unsigned DW          = 128,
    parameter int unsigned PACKET_SIZE = 2,
    parameter int unsigned FRAME_SIZE  = 256,
    parameter int unsigned GAP_CYCLES  = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic [15:0]   frames_to_send,
    output logic          busy,
    output logic          done,
    output logic [63:0]   beat_count,
    output logic [31:0]   packet_count,
    output logic [DW-1:0] axis_out_tdata,
    output logic          axis_out_tvalid,
    output logic          axis_out_tlast,
    output logic          axis_out_tuser,
    input  logic          axis_out_tready
);

    localparam int unsigned BIP_W = (PACKET_SIZE > 1) ? $clog2(PACKET_SIZE) : 1;
    localparam int unsigned BIF_W = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [BIP_W-1:0] BIP_LAST = BIP_W'(PACKET_SIZE - 1);
    localparam logic [BIF_W-1:0] BIF_LAST = BIF_W'(FRAME_SIZE - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    if ((PACKET_SIZE == 0) || ((FRAME_SIZE % PACKET_SIZE) != 0) || (DW < 128)) begin : g_param_check
        $error("axis_packet_source: FRAME_SIZE must be a multiple of PACKET_SIZE and DW >= 128");
    end

    state_e               state_q, state_d;
    logic [15:0]          frames_q, frames_d;
    logic [SEQ_W-1:0]     seq_q, seq_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [PKT_W-1:0]     pkt_q, pkt_d;
    logic [BIP_W-1:0]     bip_q, bip_d;
    logic [BIF_W-1:0]     bif_q, bif_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic                 stop_pend_q, stop_pend_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [63:0]          beat_count_q, beat_count_d;
    logic [31:0]          packet_count_q, packet_count_d;
    logic [DW-1:0]        tdata_q, tdata_d;
    logic                 tvalid_q, tvalid_d;
    logic                 tlast_q, tlast_d;
    logic                 tuser_q, tuser_d;

    logic hs_c, pkt_end_c, frame_end_c, last_frame_c;

    // Position registers always describe the beat currently (or next) on the bus.
    always_comb begin
        state_d        = state_q;
        frames_d       = frames_q;
        seq_d          = seq_q;
        frame_d        = frame_q;
        pkt_d          = pkt_q;
        bip_d          = bip_q;
        bif_d          = bif_q;
        gap_d          = gap_q;
        stop_pend_d    = stop_pend_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        beat_count_d   = beat_count_q;
        packet_count_d = packet_count_q;

        hs_c         = tvalid_q && axis_out_tready;
        pkt_end_c    = (bip_q == BIP_LAST);
        frame_end_c  = pkt_end_c && (bif_q == BIF_LAST);
        last_frame_c = (frames_q != 16'd0) && ((frame_q + 32'd1) == {16'd0, frames_q});

        case (state_q)
            IDLE: begin
                // A start landing on the done pulse belongs to the finished run.
                if (start && !done_q) begin
                    state_d        = SEND;
                    frames_d       = frames_to_send;
                    seq_d          = '0;
                    frame_d        = '0;
                    pkt_d          = '0;
                    bip_d          = '0;
                    bif_d          = '0;
                    stop_pend_d    = 1'b0;
                    busy_d         = 1'b1;
                    beat_count_d   = '0;
                    packet_count_d = '0;
                end
            end
            SEND: begin
                if (hs_c) begin
                    seq_d        = seq_q + 64'd1;
                    beat_count_d = beat_count_q + 64'd1;
                    if (pkt_end_c) begin
                        bip_d          = '0;
                        packet_count_d = packet_count_q + 32'd1;
                        if (frame_end_c) begin
                            bif_d   = '0;
                            pkt_d   = '0;
                            frame_d = frame_q + 32'd1;
                        end else begin
                            bif_d = bif_q + BIF_W'(1);
                            pkt_d = pkt_q + 16'd1;
                        end
                        if (stop || (frame_end_c && last_frame_c)) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else if (GAP_CYCLES > 0) begin
                            state_d     = GAP;
                            gap_d       = '0;
                            stop_pend_d = 1'b0;
                        end
                    end else begin
                        bip_d = bip_q + BIP_W'(1);
                        bif_d = bif_q + BIF_W'(1);
                    end
                end
            end
            GAP: begin
                gap_d = gap_q + GAP_W'(1);
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (gap_q == GAP_LAST) begin
                    if (stop || stop_pend_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        tvalid_d = (state_d == SEND);
        tlast_d  = (bip_d == BIP_LAST);
        tuser_d  = (bif_d == '0);
        tdata_d  = '0;
        tdata_d[SEQ_LSB   +: SEQ_W]   = seq_d;
        tdata_d[FRAME_LSB +: FRAME_W] = frame_d;
        tdata_d[PKT_LSB   +: PKT_W]   = pkt_d;
        tdata_d[TAG_LSB   +: TAG_W]   = PAYLOAD_TAG;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            frames_q       <= '0;
            seq_q          <= '0;
            frame_q        <= '0;
            pkt_q          <= '0;
            bip_q          <= '0;
            bif_q          <= '0;
            gap_q          <= '0;
            stop_pend_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            beat_count_q   <= '0;
            packet_count_q <= '0;
            tdata_q        <= '0;
            tvalid_q       <= 1'b0;
            tlast_q        <= 1'b0;
            tuser_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            frames_q       <= frames_d;
            seq_q          <= seq_d;
            frame_q        <= frame_d;
            pkt_q          <= pkt_d;
            bip_q          <= bip_d;
            bif_q          <= bif_d;
            gap_q          <= gap_d;
            stop_pend_q    <= stop_pend_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            beat_count_q   <= beat_count_d;
            packet_count_q <= packet_count_d;
            tdata_q        <= tdata_d;
            tvalid_q       <= tvalid_d;
            tlast_q        <= tlast_d;
            tuser_q        <= tuser_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign beat_count      = beat_count_q;
    assign packet_count    = packet_count_q;
    assign axis_out_tdata  = tdata_q;
    assign axis_out_tvalid = tvalid_q;
    assign axis_out_tlast  = tlast_q;
    assign axis_out_tuser  = tuser_q;

endmodule
